// File: rtl/invader_formation_pkg.sv
// invader_formation_pkg: shared formation geometry, screen limits, step sizes and state encodings.
package invader_formation_pkg;
   localparam int INVADERS_H        = 11;
   localparam int INVADERS_V        = 5;
   localparam int INVADERS_N        = INVADERS_H * INVADERS_V;
   localparam int INVADERS_OFFSET_H = 32;
   localparam int INVADERS_OFFSET_V = 32;
   localparam int START_X           = 64;
   localparam int START_Y           = 48;
   localparam int STEP_X            = 4;
   localparam int STEP_Y            = 16;
   localparam int LEFT_LIMIT        = 16;
   localparam int RIGHT_LIMIT       = 624;
   localparam int BOTTOM_LIMIT      = 400;
   localparam int MIN_PERIOD        = 2;

   typedef enum logic [1:0] {IDLE, MARCH, CLEARED, LANDED} state_e;
   typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;
endpackage

// File: rtl/invader_formation_if.sv
// invader_formation_if: control inputs and formation state outputs between the game logic and the formation.
interface invader_formation_if;
   import invader_formation_pkg::*;
   logic                  frame;
   logic                  start;
   logic                  hit_valid;
   logic [5:0]            hit_index;
   logic [INVADERS_N-1:0] invaders;
   logic [9:0]            invaders_x;
   logic [9:0]            invaders_y;
   logic [5:0]            alive_count;
   logic                  wave_clear;
   logic                  landed;
   logic                  marching;

   modport master (
      output frame, start, hit_valid, hit_index,
      input  invaders, invaders_x, invaders_y, alive_count, wave_clear, landed, marching
   );
   modport slave (
      input  frame, start, hit_valid, hit_index,
      output invaders, invaders_x, invaders_y, alive_count, wave_clear, landed, marching
   );
endinterface

// File: rtl/formation_extent.sv
// formation_extent: leftmost/rightmost occupied column and lowest occupied row of the alive mask.
module formation_extent
   import invader_formation_pkg::*;
(
   input  logic [INVADERS_N-1:0] mask_i,
   output logic [3:0]            lcol_o,
   output logic [3:0]            rcol_o,
   output logic [2:0]            brow_o,
   output logic                  any_alive_o
);
   logic [INVADERS_H-1:0] col_any;
   logic [INVADERS_V-1:0] row_any;

   always_comb begin
      col_any = '0;
      row_any = '0;
      for (int r = 0; r < INVADERS_V; r++)
         for (int c = 0; c < INVADERS_H; c++) begin
            col_any[c] = col_any[c] | mask_i[r*INVADERS_H+c];
            row_any[r] = row_any[r] | mask_i[r*INVADERS_H+c];
         end
      lcol_o = '0;
      rcol_o = '0;
      brow_o = '0;
      for (int c = INVADERS_H - 1; c >= 0; c--) if (col_any[c]) lcol_o = 4'(c);
      for (int c = 0; c < INVADERS_H; c++) if (col_any[c]) rcol_o = 4'(c);
      for (int r = 0; r < INVADERS_V; r++) if (row_any[r]) brow_o = 3'(r);
   end

   assign any_alive_o = |mask_i;
endmodule

// File: rtl/invader_formation.sv
// invader_formation: alien alive mask and formation origin, marched once per period of frames,
// with hit clearing, edge descend/reverse, wave-cleared pulse and landed flag.
module invader_formation
   import invader_formation_pkg::*;
(
   input logic                clk,
   input logic                arst_n,
   invader_formation_if.slave bus
);
   state_e                state_q, state_d;
   dir_e                  dir_q, dir_d;
   logic [INVADERS_N-1:0] mask_q, mask_d;
   logic [9:0]            x_q, x_d, y_q, y_d;
   logic [5:0]            cnt_q, cnt_d, alive_q, alive_d;
   logic                  landed_q, landed_d, wclr_q, wclr_d;
   logic [3:0]            lcol, rcol;
   logic [2:0]            brow;
   logic                  any_alive;
   logic [5:0]            period;
   logic                  due, hit_ok, step_ok, land_hit;
   logic [10:0]           xw, desc_y, new_right;
   logic signed [10:0]    new_left;

   formation_extent u_ext (
      .mask_i      (mask_q),
      .lcol_o      (lcol),
      .rcol_o      (rcol),
      .brow_o      (brow),
      .any_alive_o (any_alive)
   );

   // Extents come from the registered (pre-hit) mask so a coincident hit cannot shift this frame's move.
   assign xw        = {1'b0, x_q};
   assign new_right = xw + 11'((int'(rcol) + 1) * INVADERS_OFFSET_H + STEP_X);
   assign new_left  = $signed(xw + 11'(int'(lcol) * INVADERS_OFFSET_H) - 11'(STEP_X));
   assign desc_y    = {1'b0, y_q} + 11'(STEP_Y);
   assign land_hit  = desc_y + 11'((int'(brow) + 1) * INVADERS_OFFSET_V) >= 11'(BOTTOM_LIMIT);
   assign step_ok   = dir_q == DIR_RIGHT ? new_right <= 11'(RIGHT_LIMIT)
                                         : new_left >= $signed(11'(LEFT_LIMIT));
   assign period    = alive_q < 6'(MIN_PERIOD) ? 6'(MIN_PERIOD) : alive_q;
   assign due       = cnt_q >= period - 6'd1;
   assign hit_ok    = bus.hit_valid && bus.hit_index < 6'(INVADERS_N) && mask_q[bus.hit_index];

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      mask_d   = mask_q;
      x_d      = x_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      alive_d  = alive_q;
      landed_d = landed_q;
      wclr_d   = 1'b0;
      if (bus.start) begin
         state_d  = MARCH;
         dir_d    = DIR_RIGHT;
         mask_d   = '1;
         x_d      = 10'(START_X);
         y_d      = 10'(START_Y);
         cnt_d    = '0;
         alive_d  = 6'(INVADERS_N);
         landed_d = 1'b0;
      end else if (state_q == MARCH) begin
         if (bus.frame) begin
            cnt_d = due ? '0 : cnt_q + 6'd1;
            if (due && any_alive) begin
               if (step_ok) begin
                  x_d = dir_q == DIR_RIGHT ? x_q + 10'(STEP_X) : x_q - 10'(STEP_X);
               end else begin
                  y_d   = desc_y[9:0];
                  dir_d = dir_q == DIR_RIGHT ? DIR_LEFT : DIR_RIGHT;
                  if (land_hit) begin
                     landed_d = 1'b1;
                     state_d  = LANDED;
                  end
               end
            end
         end
         if (hit_ok) begin
            mask_d[bus.hit_index] = 1'b0;
            alive_d = alive_q - 6'd1;
            if (alive_q == 6'd1) begin
               wclr_d  = 1'b1;
               state_d = CLEARED;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= IDLE;
         dir_q    <= DIR_RIGHT;
         mask_q   <= '0;
         x_q      <= 10'(START_X);
         y_q      <= 10'(START_Y);
         cnt_q    <= '0;
         alive_q  <= '0;
         landed_q <= 1'b0;
         wclr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         mask_q   <= mask_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cnt_q    <= cnt_d;
         alive_q  <= alive_d;
         landed_q <= landed_d;
         wclr_q   <= wclr_d;
      end
   end

   assign bus.invaders    = mask_q;
   assign bus.invaders_x  = x_q;
   assign bus.invaders_y  = y_q;
   assign bus.alive_count = alive_q;
   assign bus.wave_clear  = wclr_q;
   assign bus.landed      = landed_q;
   assign bus.marching    = state_q == MARCH;
endmodule

// File: tb/tb_invader_formation.sv
// tb_invader_formation: directed stimulus against an integer-level formation model checked every cycle,
// plus hand-computed positions at the march, turn, landing and wave-clear points.
module tb_invader_formation;
   logic clk;
   logic arst_n;
   invader_formation_if bus ();

   invader_formation dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec = 0;
   int mis = 0;
   bit chk_en = 0;

   logic [54:0] m_inv;
   int m_x, m_y, m_cnt, m_st;
   bit m_dir, m_land, m_wc;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      m_inv = '0; m_x = 64; m_y = 48; m_dir = 0; m_cnt = 0; m_st = 0; m_land = 0; m_wc = 0;
   endtask

   // Formation rules in plain integers; m_st: 0 idle, 1 march, 2 cleared, 3 landed.
   task automatic model(input bit f, input bit s, input bit hv, input int hi);
      int n, lc, rc, br, per;
      bit kill;
      n = 0; lc = 99; rc = -1; br = -1;
      for (int i = 0; i < 55; i++)
         if (m_inv[i]) begin
            n++;
            if (i % 11 < lc) lc = i % 11;
            if (i % 11 > rc) rc = i % 11;
            if (i / 11 > br) br = i / 11;
         end
      m_wc = 0;
      if (s) begin
         m_inv = '1; m_x = 64; m_y = 48; m_dir = 0; m_cnt = 0; m_land = 0; m_st = 1;
         return;
      end
      if (m_st != 1) return;
      kill = hv && hi < 55 && m_inv[hi];
      if (f) begin
         per = n < 2 ? 2 : n;
         if (m_cnt >= per - 1) begin
            m_cnt = 0;
            if (m_dir == 0 ? (m_x + (rc + 1) * 32 + 4 <= 624) : (m_x + lc * 32 - 4 >= 16))
               m_x += m_dir ? -4 : 4;
            else begin
               m_y += 16;
               m_dir = !m_dir;
               if (m_y + (br + 1) * 32 >= 400) begin
                  m_land = 1;
                  m_st = 3;
               end
            end
         end else m_cnt++;
      end
      if (kill) begin
         m_inv[hi] = 1'b0;
         if (n == 1) begin
            m_wc = 1;
            m_st = 2;
         end
      end
   endtask

   always @(negedge clk)
      if (chk_en && arst_n) begin
         chk("invaders", 64'(bus.invaders), 64'(m_inv));
         chk("x", 64'(bus.invaders_x), 64'(m_x));
         chk("y", 64'(bus.invaders_y), 64'(m_y));
         chk("alive_count", 64'(bus.alive_count), 64'($countones(m_inv)));
         chk("wave_clear", 64'(bus.wave_clear), 64'(m_wc));
         chk("landed", 64'(bus.landed), 64'(m_land));
         chk("marching", 64'(bus.marching), 64'(m_st == 1));
      end

   task automatic step(input bit f, input bit s, input bit hv, input int hi);
      @(negedge clk);
      #1;
      bus.frame = f; bus.start = s; bus.hit_valid = hv; bus.hit_index = 6'(hi);
      model(f, s, hv, hi);
      @(posedge clk);
      #1;
      bus.frame = 0; bus.start = 0; bus.hit_valid = 0; bus.hit_index = 0;
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         step(1, 0, 0, 0);
         step(0, 0, 0, 0);
      end
   endtask

   initial begin
      bus.frame = 0; bus.start = 0; bus.hit_valid = 0; bus.hit_index = 0;
      model_reset();
      arst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      arst_n = 1;
      chk_en = 1;
      chk("rst_invaders", 64'(bus.invaders), 64'd0);
      chk("rst_x", 64'(bus.invaders_x), 64'd64);
      chk("rst_y", 64'(bus.invaders_y), 64'd48);
      chk("rst_count", 64'(bus.alive_count), 64'd0);
      chk("rst_marching", 64'(bus.marching), 64'd0);
      // IDLE ignores hits and frames
      step(0, 0, 1, 3);
      frames(3);

      step(0, 1, 0, 0);
      chk("start_invaders", 64'(bus.invaders), 64'h7FFFFFFFFFFFFF);
      chk("start_count", 64'(bus.alive_count), 64'd55);
      chk("start_marching", 64'(bus.marching), 64'd1);
      frames(54);
      chk("x_before_first_move", 64'(bus.invaders_x), 64'd64);
      frames(1);
      chk("x_first_move", 64'(bus.invaders_x), 64'd68);
      frames(51 * 55);
      chk("x_52_moves", 64'(bus.invaders_x), 64'd272);
      frames(55);
      chk("y_first_descend", 64'(bus.invaders_y), 64'd64);
      chk("x_first_descend", 64'(bus.invaders_x), 64'd272);

      // columns 6..10 dead: right edge is column 5
      step(0, 1, 0, 0);
      for (int i = 0; i < 55; i++) if (i % 11 >= 6) step(0, 0, 1, i);
      chk("cols_count", 64'(bus.alive_count), 64'd30);
      frames(92 * 30);
      chk("cols_x_turn", 64'(bus.invaders_x), 64'd432);
      chk("cols_y_before", 64'(bus.invaders_y), 64'd48);
      frames(30);
      chk("cols_x_after", 64'(bus.invaders_x), 64'd432);
      chk("cols_y_after", 64'(bus.invaders_y), 64'd64);

      // keep corners of row 4 only: full-width extents, period 2
      step(0, 1, 0, 0);
      for (int i = 0; i < 54; i++) if (i != 44) step(0, 0, 1, i);
      for (int i = 0; i < 2000 && !bus.landed; i++) frames(1);
      chk("land_flag", 64'(bus.landed), 64'd1);
      chk("land_y", 64'(bus.invaders_y), 64'd240);
      chk("land_x", 64'(bus.invaders_x), 64'd16);
      chk("land_marching", 64'(bus.marching), 64'd0);
      frames(4);
      step(0, 0, 1, 44);
      chk("land_hold_y", 64'(bus.invaders_y), 64'd240);
      step(0, 1, 0, 0);
      chk("restart_landed", 64'(bus.landed), 64'd0);

      // dead and out-of-range hits, then hit coincident with a move
      step(0, 0, 1, 5);
      step(0, 0, 1, 5);
      step(0, 0, 1, 60);
      chk("dead_oor_count", 64'(bus.alive_count), 64'd54);
      frames(53);
      step(1, 0, 1, 7);
      chk("coincident_x", 64'(bus.invaders_x), 64'd68);
      chk("coincident_count", 64'(bus.alive_count), 64'd53);
      frames(5);

      // asynchronous reset mid-march
      @(negedge clk); #1;
      arst_n = 0;
      model_reset();
      #1;
      chk("arst_invaders", 64'(bus.invaders), 64'd0);
      chk("arst_x", 64'(bus.invaders_x), 64'd64);
      chk("arst_count", 64'(bus.alive_count), 64'd0);
      chk("arst_marching", 64'(bus.marching), 64'd0);
      @(negedge clk); #1;
      arst_n = 1;

      // last alien: period 2, then wave clear
      step(0, 1, 0, 0);
      for (int i = 0; i < 54; i++) step(0, 0, 1, i);
      chk("last_count", 64'(bus.alive_count), 64'd1);
      frames(4);
      chk("last_x", 64'(bus.invaders_x), 64'd72);
      step(0, 0, 1, 54);
      chk("wave_clear_pulse", 64'(bus.wave_clear), 64'd1);
      chk("wave_clear_count", 64'(bus.alive_count), 64'd0);
      chk("wave_clear_marching", 64'(bus.marching), 64'd0);
      step(0, 0, 0, 0);
      chk("wave_clear_drop", 64'(bus.wave_clear), 64'd0);
      frames(4);
      chk("cleared_x_hold", 64'(bus.invaders_x), 64'd72);

      @(negedge clk);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end
endmodule
